branch_redirect_ctrl: RTL

Sequencer for control-transfer instructions between decode and fetch. It accepts one branch/jump at a time from decode over a valid/ready handshake and evaluates the condition through a comparator sub-module. It then computes the target, drives a fetch redirect with its own handshake, and holds a pipeline flush for a fixed number of cycles. It also returns the JAL/JALR link value to writeback and flags misaligned targets.

---
 rtl/branch_ctrl_pkg.sv | 29 ++
 rtl/branch_cond_eval.sv | 32 +++
 rtl/branch_redirect_ctrl.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/branch_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : branch_ctrl_pkg
// Purpose  : Opcode/funct3 encodings and FSM state type for the branch
//            redirect controller.
// Revision : 1.0
// ============================================================================
package branch_ctrl_pkg;

    localparam logic [4:0] OPC_BRANCH = 5'b11000;
    localparam logic [4:0] OPC_JAL    = 5'b11011;
    localparam logic [4:0] OPC_JALR   = 5'b11001;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_EVAL     = 2'd1,
        S_REDIRECT = 2'd2,
        S_FLUSH    = 2'd3
    } br_state_e;

endpackage
`default_nettype wire

// File: rtl/branch_cond_eval.sv
`default_nettype none
// ============================================================================
// Module   : branch_cond_eval
// Purpose  : Combinational branch condition evaluation from funct3.
// Revision : 1.0
// ============================================================================
module branch_cond_eval
    import branch_ctrl_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] i_rs1,
    input  logic [XLEN-1:0] i_rs2,
    input  logic [2:0]      i_fun_3,
    output logic            o_cond_true
);

    always_comb begin
        o_cond_true = 1'b0;
        case (i_fun_3)
            F3_BEQ:  o_cond_true = (i_rs1 == i_rs2);
            F3_BNE:  o_cond_true = (i_rs1 != i_rs2);
            F3_BLT:  o_cond_true = ($signed(i_rs1) <  $signed(i_rs2));
            F3_BGE:  o_cond_true = ($signed(i_rs1) >= $signed(i_rs2));
            F3_BLTU: o_cond_true = (i_rs1 <  i_rs2);
            F3_BGEU: o_cond_true = (i_rs1 >= i_rs2);
            default: o_cond_true = 1'b0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/branch_redirect_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : branch_redirect_ctrl
// Purpose  : Resolves one branch/jump at a time, issues the fetch redirect,
//            holds the pipeline flush and returns the JAL/JALR link value.
// Revision : 1.0
// ============================================================================
module branch_redirect_ctrl
    import branch_ctrl_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic            clk_in,
    input  logic            reset_in,
    input  logic            br_valid_in,
    output logic            br_ready_o,
    input  logic [XLEN-1:0] pc_in,
    input  logic [XLEN-1:0] imm_in,
    input  logic [4:0]      opcode_6_2_in,
    input  logic [2:0]      fun_3_in,
    input  logic [XLEN-1:0] rs1_in,
    input  logic [XLEN-1:0] rs2_in,
    input  logic            kill_in,
    output logic            redirect_valid_o,
    input  logic            redirect_ready_in,
    output logic [XLEN-1:0] redirect_pc_o,
    output logic            flush_o,
    output logic            resolve_valid_o,
    output logic            resolve_taken_o,
    output logic            link_valid_o,
    output logic [XLEN-1:0] link_data_o,
    output logic            misalign_o
);

    br_state_e       r_state;
    br_state_e       w_state_nxt;

    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_imm;
    logic [XLEN-1:0] r_rs1;
    logic [XLEN-1:0] r_rs2;
    logic [4:0]      r_opcode;
    logic [2:0]      r_fun_3;
    logic [XLEN-1:0] r_target;
    logic [XLEN-1:0] r_link_data;
    logic [3:0]      r_flush_cnt;
    logic            r_resolve_valid;
    logic            r_resolve_taken;
    logic            r_link_valid;
    logic            r_misalign;

    logic            w_cond_true;
    logic            w_is_branch;
    logic            w_is_jal;
    logic            w_is_jalr;
    logic            w_taken;
    logic            w_misalign;
    logic            w_accept;
    logic            w_redirect_fire;
    logic [XLEN-1:0] w_pc_sum;
    logic [XLEN-1:0] w_jalr_sum;
    logic [XLEN-1:0] w_target;

    branch_cond_eval #(
        .XLEN(XLEN)
    ) u_cond_eval (
        .i_rs1       (r_rs1),
        .i_rs2       (r_rs2),
        .i_fun_3     (r_fun_3),
        .o_cond_true (w_cond_true)
    );

    assign w_is_branch     = (r_opcode == OPC_BRANCH);
    assign w_is_jal        = (r_opcode == OPC_JAL);
    assign w_is_jalr       = (r_opcode == OPC_JALR);
    assign w_pc_sum        = r_pc + r_imm;
    assign w_jalr_sum      = r_rs1 + r_imm;
    assign w_target        = w_is_jalr ? {w_jalr_sum[XLEN-1:1], 1'b0} : w_pc_sum;
    assign w_taken         = w_is_branch ? w_cond_true : (w_is_jal | w_is_jalr);
    assign w_misalign      = w_taken & (w_target[1:0] != 2'b00);
    assign w_accept        = (r_state == S_IDLE) & br_valid_in & ~kill_in;
    // kill takes priority over a coincident fetch handshake
    assign w_redirect_fire = (r_state == S_REDIRECT) & redirect_ready_in & ~kill_in;

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) w_state_nxt = S_EVAL;
            end
            S_EVAL: begin
                if (kill_in)                     w_state_nxt = S_IDLE;
                else if (w_taken && !w_misalign) w_state_nxt = S_REDIRECT;
                else                             w_state_nxt = S_IDLE;
            end
            S_REDIRECT: begin
                if (kill_in)              w_state_nxt = S_IDLE;
                else if (w_redirect_fire) w_state_nxt = S_FLUSH;
            end
            S_FLUSH: begin
                if (kill_in || (r_flush_cnt == 4'd1)) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            r_pc            <= '0;
            r_imm           <= '0;
            r_rs1           <= '0;
            r_rs2           <= '0;
            r_opcode        <= '0;
            r_fun_3         <= '0;
            r_target        <= '0;
            r_link_data     <= '0;
            r_flush_cnt     <= '0;
            r_resolve_valid <= 1'b0;
            r_resolve_taken <= 1'b0;
            r_link_valid    <= 1'b0;
            r_misalign      <= 1'b0;
        end else begin
            r_resolve_valid <= 1'b0;
            r_resolve_taken <= 1'b0;
            r_link_valid    <= 1'b0;
            r_misalign      <= 1'b0;

            if (w_accept) begin
                r_pc     <= pc_in;
                r_imm    <= imm_in;
                r_rs1    <= rs1_in;
                r_rs2    <= rs2_in;
                r_opcode <= opcode_6_2_in;
                r_fun_3  <= fun_3_in;
            end

            if ((r_state == S_EVAL) && !kill_in) begin
                r_resolve_valid <= 1'b1;
                r_resolve_taken <= w_taken;
                r_link_valid    <= (w_is_jal | w_is_jalr) & ~w_misalign;
                r_misalign      <= w_misalign;
                r_target        <= w_target;
                if (w_is_jal || w_is_jalr) r_link_data <= r_pc + XLEN'(4);
            end

            if (w_redirect_fire) begin
                r_flush_cnt <= 4'(FLUSH_CYCLES);
            end else if (r_state == S_FLUSH) begin
                r_flush_cnt <= r_flush_cnt - 4'd1;
            end
        end
    end

    assign br_ready_o       = (r_state == S_IDLE);
    assign redirect_valid_o = (r_state == S_REDIRECT);
    assign flush_o          = (r_state == S_FLUSH);
    assign redirect_pc_o    = r_target;
    assign resolve_valid_o  = r_resolve_valid;
    assign resolve_taken_o  = r_resolve_taken;
    assign link_valid_o     = r_link_valid;
    assign link_data_o      = r_link_data;
    assign misalign_o       = r_misalign;

endmodule
`default_nettype wire
